ysyx_22040088_ifu: RTL
======================

Name: ysyx_22040088_ifu

Overview:
Instruction fetch stage of the 5-stage RV64 pipeline, directly upstream of the decode stage. It owns the PC register and issues one aligned 64-bit fetch at a time to instruction memory over a valid/ready request and valid response interface. It selects the 32-bit instruction half and drives the IF/ID pipeline register (valid, pc, inst). It honours decode-stage stall and branch/jump redirect, and squashes wrong-path fetches.

Parameters:
RESET_PC, 64'h8000_0000, PC value loaded on reset.
NOP_INST, 32'h0000_0013, instruction word delivered with a misalignment fault.

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, asynchronous, active-low (0 = reset)
redirect_valid  in  1  decode resolved taken branch/jump this cycle
redirect_pc  in  64  target PC
id_stall  in  1  decode stage stalled; IF/ID register must hold
imem_req_valid  out  1  fetch request
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  64  {pc[63:3],3'b000}
imem_resp_valid  in  1  fetch data returned (exactly one per accepted request, ≥1 cycle later)
imem_resp_data  in  64  aligned doubleword
id_valid  out  1  IF/ID register holds a live instruction
id_pc  out  64  PC of id_inst
id_inst  out  32  instruction word
id_misalign  out  1  id_pc[1:0] != 0 fault marker

Behaviour:
- Reset (rst=0, asynchronous): pc_q=RESET_PC, state=IDLE, drop_q=0, id_valid=0, id_pc=0, id_inst=0, id_misalign=0, buffer empty. imem_req_valid=0 while rst=0.
- redirect_valid is ignored when id_stall=1; effective redirect is redir = redirect_valid & ~id_stall.
- States: IDLE, WAIT, HOLD, FAULT.
- IDLE:
  - imem_req_valid = ~redir & (pc_q[1:0]==0).
  - Handshake (valid&ready) -> WAIT, fetch_pc_q<=pc_q.
  - If pc_q[1:0]!=0 and no redir -> FAULT.
- WAIT:
  - imem_req_valid=0.
  - On imem_resp_valid:
    - If drop_q=1: discard, clear drop_q, -> IDLE.
    - Else inst = fetch_pc_q[2] ? data[63:32] : data[31:0].
    - If IF/ID free (id_valid=0 or id_stall=0): load id_* (id_misalign=0), id_valid<=1, pc_q<=fetch_pc_q+4, -> IDLE. Response-to-id_valid latency is 1 cycle.
    - Else store inst/pc in hold buffer, -> HOLD.
- HOLD: when id_stall=0, move buffer into id_*, pc_q<=buf_pc+4, -> IDLE.
- FAULT:
  - Load id_pc=pc_q, id_inst=NOP_INST, id_misalign=1, id_valid=1 once, when IF/ID is free.
  - No further requests until a redirect.
- IF/ID register:
  - If id_stall=1: all id_* hold.
  - Else, if no new instruction is loaded this cycle: id_valid<=0 (bubble).
- Redirect (highest priority over all of the above):
  - pc_q<=redirect_pc.
  - The instruction in IF/ID (the branch) is consumed normally; the new id_valid<=0, so the wrong-path fetch never enters decode.
  - In WAIT: drop_q<=1, unless imem_resp_valid arrives the same cycle, in which case that data is discarded and the state goes to IDLE.
  - In HOLD: discard the buffer, -> IDLE.
  - In FAULT: -> IDLE.
- At most one outstanding request. PC arithmetic is modulo 2^64 (0xFFFF_FFFF_FFFF_FFFC+4 wraps to 0).
- A redirect to a misaligned target is accepted; the fault is reported via FAULT, never sent to memory.

Decomposition:
- Shared package: RESET_PC and NOP_INST constants; IFU state enum (IDLE/WAIT/HOLD/FAULT); 64-bit address and 32-bit instruction typedefs.
- No sub-module is natural. The hold buffer plus half-select are under 30 lines and stay inline.

Test Plan:
- Reset release, memory ready=1 with 1-cycle response, data 64'h00100093_00000013 at 0x80000000:
  - id pc/inst sequence 0x80000000/0x00000013, then 0x80000004/0x00100093.
  - imem_req_addr 0x80000000 both times.
- id_stall=1 for 3 cycles while a response returns:
  - id_* held unchanged; FSM in HOLD.
  - After release, buffered inst appears next cycle; no instruction lost or duplicated.
- redirect_valid=1, redirect_pc=0x80000100 while in WAIT:
  - Returning data discarded, next id_valid=0.
  - Next request addr 0x80000100; first delivered id_pc=0x80000100.
- redirect_valid=1 with id_stall=1:
  - pc_q unchanged.
  - Redirect honoured only in the first cycle with id_stall=0.
- Redirect to 0x80000102:
  - No imem request.
  - id_valid=1, id_misalign=1, id_inst=0x00000013, id_pc=0x80000102.
  - Then idle until redirect to 0x80000200 resumes fetching.
- Assert rst=0 mid-WAIT:
  - Outputs zero immediately (asynchronously); pc_q=0x80000000.
  - A stray late response after release is not delivered to id_*.

Source files
------------

// File: rtl/ysyx_22040088_ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ysyx_22040088_ifu_pkg;

  typedef logic [63:0] addr_t;
  typedef logic [31:0] inst_t;

  localparam addr_t DEFAULT_RESET_PC = 64'h0000_0000_8000_0000;
  localparam inst_t DEFAULT_NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    IFU_IDLE,
    IFU_WAIT,
    IFU_HOLD,
    IFU_FAULT
  } ifu_state_e;

  // The instruction sits in the upper word when pc[2] is set.
  function automatic inst_t select_half(input addr_t pc, input logic [63:0] dword);
    return pc[2] ? dword[63:32] : dword[31:0];
  endfunction

endpackage

// File: rtl/ysyx_22040088_ifu.sv
// Instruction fetch stage: owns the PC, issues one aligned doubleword fetch at a
// time, and feeds the IF/ID register with stall, redirect and misalignment handling.
module ysyx_22040088_ifu
  import ysyx_22040088_ifu_pkg::*;
#(
  parameter addr_t RESET_PC = DEFAULT_RESET_PC,
  parameter inst_t NOP_INST = DEFAULT_NOP_INST
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  input  logic        id_stall,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [63:0] imem_resp_data,
  output logic        id_valid,
  output logic [63:0] id_pc,
  output logic [31:0] id_inst,
  output logic        id_misalign
);

  ifu_state_e state_q, state_d;
  addr_t      pc_q, pc_d;
  addr_t      fetch_pc_q, fetch_pc_d;
  logic       drop_q, drop_d;
  logic       fault_sent_q, fault_sent_d;
  addr_t      buf_pc_q, buf_pc_d;
  inst_t      buf_inst_q, buf_inst_d;

  logic       id_valid_q;
  addr_t      id_pc_q;
  inst_t      id_inst_q;
  logic       id_misalign_q;

  logic       redir;
  logic       id_free;
  logic       pc_misaligned;
  inst_t      fetch_inst;
  logic       ld_valid;
  addr_t      ld_pc;
  inst_t      ld_inst;
  logic       ld_misalign;

  assign redir         = redirect_valid & ~id_stall;
  assign id_free       = ~id_valid_q | ~id_stall;
  assign pc_misaligned = |pc_q[1:0];
  assign fetch_inst    = select_half(fetch_pc_q, imem_resp_data);

  assign imem_req_valid = rst & (state_q == IFU_IDLE) & ~redir & ~pc_misaligned;
  assign imem_req_addr  = {pc_q[63:3], 3'b000};

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d      = state_q;
    pc_d         = pc_q;
    fetch_pc_d   = fetch_pc_q;
    drop_d       = drop_q;
    fault_sent_d = fault_sent_q;
    buf_pc_d     = buf_pc_q;
    buf_inst_d   = buf_inst_q;
    ld_valid     = 1'b0;
    ld_pc        = fetch_pc_q;
    ld_inst      = fetch_inst;
    ld_misalign  = 1'b0;

    case (state_q)
      IFU_IDLE: begin
        if (pc_misaligned) begin
          state_d = IFU_FAULT;
        end else if (imem_req_valid && imem_req_ready) begin
          state_d    = IFU_WAIT;
          fetch_pc_d = pc_q;
        end
      end
      IFU_WAIT: begin
        if (imem_resp_valid) begin
          if (drop_q) begin
            drop_d  = 1'b0;
            state_d = IFU_IDLE;
          end else if (id_free) begin
            ld_valid = 1'b1;
            pc_d     = fetch_pc_q + 64'd4;
            state_d  = IFU_IDLE;
          end else begin
            buf_pc_d   = fetch_pc_q;
            buf_inst_d = fetch_inst;
            state_d    = IFU_HOLD;
          end
        end
      end
      IFU_HOLD: begin
        if (!id_stall) begin
          ld_valid = 1'b1;
          ld_pc    = buf_pc_q;
          ld_inst  = buf_inst_q;
          pc_d     = buf_pc_q + 64'd4;
          state_d  = IFU_IDLE;
        end
      end
      IFU_FAULT: begin
        if (id_free && !fault_sent_q) begin
          ld_valid     = 1'b1;
          ld_pc        = pc_q;
          ld_inst      = NOP_INST;
          ld_misalign  = 1'b1;
          fault_sent_d = 1'b1;
        end
      end
      default: state_d = IFU_IDLE;
    endcase

    // A redirect overrides everything; an in-flight fetch is either dropped now
    // (response this cycle) or remembered in drop_q for when it returns.
    if (redir) begin
      pc_d         = redirect_pc;
      ld_valid     = 1'b0;
      fault_sent_d = 1'b0;
      drop_d       = (state_q == IFU_WAIT) & ~imem_resp_valid;
      state_d      = drop_d ? IFU_WAIT : IFU_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst) begin
      state_q      <= IFU_IDLE;
      pc_q         <= RESET_PC;
      fetch_pc_q   <= '0;
      drop_q       <= 1'b0;
      fault_sent_q <= 1'b0;
      buf_pc_q     <= '0;
      buf_inst_q   <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      fetch_pc_q   <= fetch_pc_d;
      drop_q       <= drop_d;
      fault_sent_q <= fault_sent_d;
      buf_pc_q     <= buf_pc_d;
      buf_inst_q   <= buf_inst_d;
    end
  end

  // A load only happens when IF/ID is free, so it may proceed under stall when empty.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      id_valid_q    <= 1'b0;
      id_pc_q       <= '0;
      id_inst_q     <= '0;
      id_misalign_q <= 1'b0;
    end else if (ld_valid) begin
      id_valid_q    <= 1'b1;
      id_pc_q       <= ld_pc;
      id_inst_q     <= ld_inst;
      id_misalign_q <= ld_misalign;
    end else if (!id_stall) begin
      id_valid_q    <= 1'b0;
    end
  end

  assign id_valid    = id_valid_q;
  assign id_pc       = id_pc_q;
  assign id_inst     = id_inst_q;
  assign id_misalign = id_misalign_q;

endmodule
